// File: rtl/adc_pkt_sequencer_pkg.sv
// adc_seq_pkg: shared state, beat type and constants for the ADC packet sequencer
package adc_seq_pkg;
   localparam int SAMPLES_PER_BEAT = 8;
   localparam int EMPTY_W = 6;
   localparam int BEAT_W = 512;
   typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, TERMINATE} seq_state_t;
   typedef struct packed {
      logic [BEAT_W-1:0] data;
      logic sop;
      logic eop;
      logic [EMPTY_W-1:0] empty;
   } beat_t;
   // unused bytes in the last beat of a packet whose length is n_mod modulo 8
   function automatic logic [EMPTY_W-1:0] eop_empty(input logic [2:0] n_mod);
      return {3'd0 - n_mod, 3'b000};
   endfunction
endpackage

// File: rtl/adc_pkt_sequencer_fifo.sv
// adc_beat_fifo: two-entry show-ahead FIFO of packed stream beats
module adc_beat_fifo
   import adc_seq_pkg::*;
(
   input  logic  clk,
   input  logic  reset_n,
   input  logic  push,
   input  beat_t wr_beat,
   input  logic  pop,
   output beat_t rd_beat,
   output logic  full,
   output logic  empty
);
   beat_t mem [2];
   logic wr_ptr, rd_ptr, do_push, do_pop;
   logic [1:0] cnt;
   assign full = cnt == 2'd2;
   assign empty = cnt == 2'd0;
   assign do_pop = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rd_beat = mem[rd_ptr];
   // pointer and occupancy tracking; a pop frees a full slot for a same-cycle push
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt <= 2'd0;
      end else begin
         if (do_push) wr_ptr <= ~wr_ptr;
         if (do_pop) rd_ptr <= ~rd_ptr;
         cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
      end
   end
   // storage is only read after being written, so it carries no reset
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_beat;
   end
endmodule

// File: rtl/adc_pkt_sequencer.sv
// adc_pkt_sequencer: packs ADC samples into framed 512-bit stream packets under trigger/run control
module adc_pkt_sequencer
   import adc_seq_pkg::*;
#(
   parameter int SAMPLE_W = 64,
   parameter int DATA_W = 512,
   parameter int LEN_W = 16,
   parameter int CNT_W = 32
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                cfg_arm,
   input  logic                cfg_abort,
   input  logic [LEN_W-1:0]    cfg_samples,
   input  logic [LEN_W-1:0]    cfg_packets,
   input  logic                cfg_trig_ext,
   input  logic                trig_in,
   input  logic [SAMPLE_W-1:0] adc_data,
   input  logic                adc_valid,
   output logic [DATA_W-1:0]   st_data,
   output logic                st_valid,
   input  logic                st_ready,
   output logic                st_sop,
   output logic                st_eop,
   output logic [EMPTY_W-1:0]  st_empty,
   output logic                stat_busy,
   output logic                stat_done,
   output logic                stat_ovf,
   output logic [CNT_W-1:0]    stat_pkt_cnt
);
   seq_state_t state;
   logic [LEN_W-1:0] n_lat, p_lat, samp_idx, pkt_idx;
   logic [DATA_W-1:0] beat_buf;
   logic [EMPTY_W-1:0] pend_empty;
   logic [2:0] slot;
   logic ext_lat, trig_prev, pend_valid, pend_sop, pend_eop, pkt_open, run_ok;
   logic fifo_full, fifo_empty, term_push, push, pop, push_ok, ovf, open_after, last_smp, run_end;
   beat_t wr_beat, rd_beat;
   adc_beat_fifo u_fifo (
      .clk(clk), .reset_n(reset_n), .push(push), .wr_beat(wr_beat), .pop(pop),
      .rd_beat(rd_beat), .full(fifo_full), .empty(fifo_empty)
   );
   assign st_valid = ~fifo_empty;
   assign st_data = st_valid ? rd_beat.data : '0;
   assign st_sop = st_valid & rd_beat.sop;
   assign st_eop = st_valid & rd_beat.eop;
   assign st_empty = st_valid ? rd_beat.empty : '0;
   assign stat_busy = state != IDLE || !fifo_empty || pend_valid;
   // beat push arbitration, overflow detection and packet position decode
   always_comb begin
      slot = samp_idx[2:0];
      last_smp = samp_idx == n_lat - LEN_W'(1);
      run_end = p_lat != '0 && pkt_idx == p_lat - LEN_W'(1);
      pop = ~fifo_empty & st_ready;
      term_push = state == TERMINATE && (!fifo_full || pop);
      push = pend_valid | term_push;
      push_ok = push & (~fifo_full | pop);
      ovf = push & fifo_full & ~pop;
      wr_beat.data = term_push ? '0 : beat_buf;
      wr_beat.sop = term_push ? 1'b0 : pend_sop;
      wr_beat.eop = term_push ? 1'b1 : pend_eop;
      wr_beat.empty = term_push ? '0 : pend_empty;
      open_after = push_ok ? ~wr_beat.eop : pkt_open;
   end
   // sequencer FSM with sample packing; overflow outranks abort, abort outranks normal flow
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         n_lat <= '0;
         p_lat <= '0;
         ext_lat <= 1'b0;
         samp_idx <= '0;
         pkt_idx <= '0;
         beat_buf <= '0;
         trig_prev <= 1'b0;
         pend_valid <= 1'b0;
         pend_sop <= 1'b0;
         pend_eop <= 1'b0;
         pend_empty <= '0;
         pkt_open <= 1'b0;
         run_ok <= 1'b0;
         stat_done <= 1'b0;
         stat_ovf <= 1'b0;
         stat_pkt_cnt <= '0;
      end else begin
         trig_prev <= trig_in;
         pend_valid <= 1'b0;
         if (push_ok) pkt_open <= ~wr_beat.eop;
         if (pop && rd_beat.eop && stat_pkt_cnt != '1) stat_pkt_cnt <= stat_pkt_cnt + CNT_W'(1);
         if (state == IDLE && run_ok && !pend_valid && fifo_empty) stat_done <= 1'b1;
         if (ovf) begin
            stat_ovf <= 1'b1;
            run_ok <= 1'b0;
            samp_idx <= '0;
            state <= pkt_open ? TERMINATE : IDLE;
         end else if (cfg_abort && (state == WAIT_TRIG || state == CAPTURE)) begin
            samp_idx <= '0;
            state <= open_after ? TERMINATE : IDLE;
         end else begin
            case (state)
               IDLE: if (cfg_arm) begin
                  n_lat <= cfg_samples == '0 ? LEN_W'(1) : cfg_samples;
                  p_lat <= cfg_packets;
                  ext_lat <= cfg_trig_ext;
                  samp_idx <= '0;
                  pkt_idx <= '0;
                  run_ok <= 1'b0;
                  stat_done <= 1'b0;
                  stat_ovf <= 1'b0;
                  stat_pkt_cnt <= '0;
                  state <= cfg_trig_ext ? WAIT_TRIG : CAPTURE;
               end
               WAIT_TRIG: if (trig_in && !trig_prev) state <= CAPTURE;
               CAPTURE: if (adc_valid) begin
                  if (slot == 3'd0) beat_buf <= DATA_W'(adc_data);
                  else beat_buf[int'(slot)*SAMPLE_W +: SAMPLE_W] <= adc_data;
                  if (slot == 3'(SAMPLES_PER_BEAT - 1) || last_smp) begin
                     pend_valid <= 1'b1;
                     pend_sop <= samp_idx < LEN_W'(SAMPLES_PER_BEAT);
                     pend_eop <= last_smp;
                     pend_empty <= last_smp ? eop_empty(n_lat[2:0]) : '0;
                  end
                  if (last_smp) begin
                     samp_idx <= '0;
                     if (p_lat != '0) pkt_idx <= pkt_idx + LEN_W'(1);
                     if (run_end) begin
                        run_ok <= 1'b1;
                        state <= IDLE;
                     end else if (ext_lat) state <= WAIT_TRIG;
                  end else samp_idx <= samp_idx + LEN_W'(1);
               end
               TERMINATE: if (term_push) state <= IDLE;
            endcase
         end
      end
   end
endmodule
